// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sa_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/serial_add_bit_full_adder.sv
// One-bit combinational full-adder cell used by the serial adder on every RUN cycle.
module bit_full_adder
  import serial_add_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = maj3(a, b, ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: valid/ready in, WIDTH LSB-first RUN cycles, valid/ready out.
// Define SERIAL_ADD_OVF_EN to compute the signed-overflow flag; otherwise ovf is tied low.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_s, co_s, last_s;
  logic [WIDTH-1:0] sum_next_s;

  bit_full_adder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (s_s),
    .co (co_s)
  );

  // New sum bit enters at the MSB; a 1-bit adder has nothing to shift.
  if (WIDTH == 1) begin : g_sum_w1
    assign sum_next_s = s_s;
  end else begin : g_sum_wn
    assign sum_next_s = {s_s, sum_sh_q[WIDTH-1:1]};
  end

  assign last_s    = (cnt_q == CNT_LAST);
  assign in_ready  = (state_q == ST_IDLE) & rst_n;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) | (state_q == ST_DONE);
  assign sum_out   = sum_q;
  assign cout      = cout_q;

  // Next-state and datapath decode
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          carry_d = cin;
          cnt_d   = {CW{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1'b1;
        b_sh_d   = b_sh_q >> 1'b1;
        sum_sh_d = sum_next_s;
        carry_d  = co_s;
        if (last_s) begin
          sum_d   = sum_next_s;
          cout_d  = co_s;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= {WIDTH{1'b0}};
      b_sh_q   <= {WIDTH{1'b0}};
      sum_sh_q <= {WIDTH{1'b0}};
      sum_q    <= {WIDTH{1'b0}};
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // Overflow = carry into MSB xor carry out of MSB, taken on the final RUN edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if ((state_q == ST_RUN) && last_s) begin
      ovf_q <= carry_q ^ co_s;
    end else begin
      ovf_q <= ovf_q;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances, hand-computed results.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
  logic [7:0] a_in, b_in, sum_out;
  logic       u1_in_valid, u1_in_ready, u1_cin, u1_out_valid, u1_out_ready, u1_cout, u1_ovf, u1_busy;
  logic [0:0] u1_a, u1_b, u1_sum;

  int n_cmp;
  int n_bad;
  int seen_valid;

`ifdef SERIAL_ADD_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .cout(cout), .ovf(ovf), .busy(busy)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(u1_in_valid), .in_ready(u1_in_ready),
    .a_in(u1_a), .b_in(u1_b), .cin(u1_cin), .out_valid(u1_out_valid), .out_ready(u1_out_ready),
    .sum_out(u1_sum), .cout(u1_cout), .ovf(u1_ovf), .busy(u1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic c);
    a_in = a;
    b_in = b;
    cin = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // After the accept edge E0: out_valid stays low through E7, rises at E8.
  task automatic wait_done(input string tag);
    for (int k = 1; k <= 7; k++) tick();
    chk({tag, "_valid_e7"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, "_valid_e8"}, 64'(out_valid), 64'd1);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drained"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle_rdy"}, 64'(in_ready), 64'd1);
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] es, input logic ec, input logic eo);
    accept(a, b, c);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_rdy_run"}, 64'(in_ready), 64'd0);
    wait_done(tag);
    chk({tag, "_sum"}, 64'(sum_out), 64'(es));
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo & OVF_ON));
    drain(tag);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a_in = 8'h00; b_in = 8'h00; cin = 1'b0;
    u1_in_valid = 1'b0; u1_out_ready = 1'b0; u1_a = 1'b0; u1_b = 1'b0; u1_cin = 1'b0;

    // Reset
    tick();
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", 64'(sum_out), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_rdy_low", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_rdy", 64'(in_ready), 64'd1);

    // Main function
    op8("t0F01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    op8("tFF01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("t7F01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("tA55A", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    op8("t8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    op8("t3C0F", 8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0);

    // Backpressure with a pending input
    accept(8'h12, 8'h34, 1'b1);
    wait_done("bp");
    a_in = 8'h03; b_in = 8'h04; cin = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_sum", 64'(sum_out), 64'h47);
      chk("bp_rdy", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_hs_valid", 64'(out_valid), 64'd0);
    chk("bp_no_accept", 64'(busy), 64'd0);
    chk("bp_hold_sum", 64'(sum_out), 64'h47);
    tick();
    in_valid = 1'b0;
    chk("bp_late_accept", 64'(busy), 64'd1);
    wait_done("bp2");
    chk("bp2_sum", 64'(sum_out), 64'h07);
    drain("bp2");

    // Reset during RUN at cnt=3
    accept(8'hAA, 8'h55, 1'b0);
    tick(); tick(); tick();
    chk("mr_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("mr_busy_clr", 64'(busy), 64'd0);
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_sum_clr", 64'(sum_out), 64'd0);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid === 1'b1) seen_valid++;
    end
    chk("mr_no_valid", 64'(seen_valid), 64'd0);
    op8("mr_next", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // WIDTH=1 instance
    chk("w1_rdy", 64'(u1_in_ready), 64'd1);
    u1_a = 1'b1; u1_b = 1'b1; u1_cin = 1'b1; u1_in_valid = 1'b1;
    tick();
    u1_in_valid = 1'b0;
    chk("w1_valid_e0", 64'(u1_out_valid), 64'd0);
    chk("w1_busy", 64'(u1_busy), 64'd1);
    tick();
    chk("w1_valid_e1", 64'(u1_out_valid), 64'd1);
    chk("w1_sum", 64'(u1_sum), 64'd1);
    chk("w1_cout", 64'(u1_cout), 64'd1);
    chk("w1_ovf", 64'(u1_ovf), 64'd0);
    u1_out_ready = 1'b1;
    tick();
    u1_out_ready = 1'b0;
    chk("w1_drained", 64'(u1_out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
